// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the digital clock: sequences time setting from two
// button pulses, drives counter load strobes, gates the 1 Hz tick and scans the display.
module clock_set_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  output logic       sec_load,
  output logic       min_load,
  output logic       hour_load,
  output logic [5:0] load_data,
  output logic       run_en,
  output logic       en_hour,
  output logic       en_min,
  output logic       en_sec,
  output logic [1:0] mode
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  mode_t              state, state_next;
  logic [5:0]         shadow, shadow_next, limit;
  logic [5:0]         load_data_next;
  logic               sec_load_next, min_load_next, hour_load_next;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         slot, slot_next, blank_slot;
  logic               blink_phase, blink_phase_next;
  logic               scan_wrap, blink_wrap, blank;

  assign mode = state;

  // Mode wins over inc; a mode step reloads the shadow from the field being entered.
  always_comb begin
    state_next     = state;
    shadow_next    = shadow;
    load_data_next = load_data;
    sec_load_next  = 1'b0;
    min_load_next  = 1'b0;
    hour_load_next = 1'b0;
    limit          = (state == SET_HR) ? 6'd23 : 6'd59;
    if (mode_btn) begin
      case (state)
        RUN:     state_next = SET_HR;
        SET_HR:  state_next = SET_MIN;
        SET_MIN: state_next = SET_SEC;
        default: state_next = RUN;
      endcase
      case (state_next)
        SET_HR:  shadow_next = {1'b0, hour_in};
        SET_MIN: shadow_next = min_in;
        SET_SEC: shadow_next = sec_in;
        default: shadow_next = shadow;
      endcase
    end else if (inc_btn && state != RUN) begin
      shadow_next    = (shadow >= limit) ? 6'd0 : shadow + 6'd1;
      load_data_next = shadow_next;
      case (state)
        SET_HR:  hour_load_next = 1'b1;
        SET_MIN: min_load_next  = 1'b1;
        SET_SEC: sec_load_next  = 1'b1;
        default: hour_load_next = 1'b0;
      endcase
    end
  end

  always_comb begin
    scan_wrap        = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    blink_wrap       = scan_wrap && (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    blink_phase_next = blink_phase ^ blink_wrap;
    slot_next        = slot;
    if (scan_wrap) slot_next = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
    // SET_HR/MIN/SEC map onto display slots 0/1/2.
    blank_slot = 2'(state_next) - 2'd1;
    blank      = blink_phase_next && (state_next != RUN) && (slot_next == blank_slot);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= RUN;
      run_en      <= 1'b1;
      shadow      <= 6'd0;
      load_data   <= 6'd0;
      sec_load    <= 1'b0;
      min_load    <= 1'b0;
      hour_load   <= 1'b0;
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      slot        <= 2'd0;
      blink_phase <= 1'b0;
      en_hour     <= 1'b1;
      en_min      <= 1'b0;
      en_sec      <= 1'b0;
    end else begin
      state       <= state_next;
      run_en      <= (state_next == RUN);
      shadow      <= shadow_next;
      load_data   <= load_data_next;
      sec_load    <= sec_load_next;
      min_load    <= min_load_next;
      hour_load   <= hour_load_next;
      scan_cnt    <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_wrap) blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
      slot        <= slot_next;
      blink_phase <= blink_phase_next;
      en_hour     <= (slot_next == 2'd0) && !blank;
      en_min      <= (slot_next == 2'd1) && !blank;
      en_sec      <= (slot_next == 2'd2) && !blank;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with a fast scan (SCAN_DIV=4, BLINK_DIV=2).
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       clear, mode_btn, inc_btn;
   logic [5:0] sec_in, min_in;
   logic [4:0] hour_in;
   logic       sec_load, min_load, hour_load, run_en, en_hour, en_min, en_sec;
   logic [5:0] load_data;
   logic [1:0] mode;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   clock_set_ctrl #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
      .clk(clk), .clear(clear), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
      .sec_load(sec_load), .min_load(min_load), .hour_load(hour_load),
      .load_data(load_data), .run_en(run_en),
      .en_hour(en_hour), .en_min(en_min), .en_sec(en_sec), .mode(mode)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic applyStimulus(input logic m, input logic i);
      mode_btn = m;
      inc_btn  = i;
      step();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic checkLoads(input string tag, input logic h, input logic m, input logic s);
      checkOutput({tag, "_hour_load"}, {7'd0, hour_load}, {7'd0, h});
      checkOutput({tag, "_min_load"},  {7'd0, min_load},  {7'd0, m});
      checkOutput({tag, "_sec_load"},  {7'd0, sec_load},  {7'd0, s});
   endtask

   task automatic checkEnables(input string tag, input logic h, input logic m, input logic s);
      checkOutput({tag, "_en_hour"}, {7'd0, en_hour}, {7'd0, h});
      checkOutput({tag, "_en_min"},  {7'd0, en_min},  {7'd0, m});
      checkOutput({tag, "_en_sec"},  {7'd0, en_sec},  {7'd0, s});
   endtask

   initial begin
      logic [1:0] exp_modes [4];
      exp_modes = '{2'd1, 2'd2, 2'd3, 2'd0};
      clear = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
      sec_in = 6'd0; min_in = 6'd0; hour_in = 5'd0;

      // Power-on reset
      step(); step();
      clear = 1'b0; cyc = 0;
      checkOutput("rst_mode", {6'd0, mode}, 8'd0);
      checkOutput("rst_run_en", {7'd0, run_en}, 8'd1);
      checkOutput("rst_load_data", {2'd0, load_data}, 8'd0);
      checkLoads("rst", 1'b0, 1'b0, 1'b0);
      checkEnables("rst", 1'b1, 1'b0, 1'b0);

      // RUN scan rotates every 4 cycles
      run_to(4);  checkEnables("scan4", 1'b0, 1'b1, 1'b0);
      run_to(8);  checkEnables("scan8", 1'b0, 1'b0, 1'b1);
      run_to(12); checkEnables("scan12", 1'b1, 1'b0, 1'b0);

      // Mode cycling, pulses 10 cycles apart
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput("cyc_mode", {6'd0, mode}, {6'd0, exp_modes[k]});
         checkOutput("cyc_run_en", {7'd0, run_en}, {7'd0, exp_modes[k] == 2'd0});
         repeat (9) step();
         checkOutput("cyc_mode_hold", {6'd0, mode}, {6'd0, exp_modes[k]});
         checkOutput("cyc_run_en_hold", {7'd0, run_en}, {7'd0, exp_modes[k] == 2'd0});
      end

      // Hour wrap 22 -> 23 -> 0
      hour_in = 5'd22;
      applyStimulus(1'b1, 1'b0);
      checkOutput("hr_mode", {6'd0, mode}, 8'd1);
      checkLoads("hr_enter", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkLoads("hr_inc1", 1'b1, 1'b0, 1'b0);
      checkOutput("hr_data1", {2'd0, load_data}, 8'd23);
      step();
      checkLoads("hr_after1", 1'b0, 1'b0, 1'b0);
      checkOutput("hr_hold1", {2'd0, load_data}, 8'd23);
      applyStimulus(1'b0, 1'b1);
      checkLoads("hr_inc2", 1'b1, 1'b0, 1'b0);
      checkOutput("hr_data2", {2'd0, load_data}, 8'd0);
      step();
      checkLoads("hr_after2", 1'b0, 1'b0, 1'b0);

      // Mode and inc together: mode wins, no load
      min_in = 6'd59;
      applyStimulus(1'b1, 1'b1);
      checkOutput("simul_mode", {6'd0, mode}, 8'd2);
      checkLoads("simul", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkLoads("min_inc", 1'b0, 1'b1, 1'b0);
      checkOutput("min_data", {2'd0, load_data}, 8'd0);

      // Out-of-range seconds
      sec_in = 6'd62;
      applyStimulus(1'b1, 1'b0);
      checkOutput("sec_mode", {6'd0, mode}, 8'd3);
      applyStimulus(1'b0, 1'b1);
      checkLoads("sec_inc", 1'b0, 1'b0, 1'b1);
      checkOutput("sec_data", {2'd0, load_data}, 8'd0);

      // inc ignored in RUN
      applyStimulus(1'b1, 1'b0);
      checkOutput("run_mode", {6'd0, mode}, 8'd0);
      checkOutput("run_run_en", {7'd0, run_en}, 8'd1);
      applyStimulus(1'b0, 1'b1);
      checkLoads("run_inc", 1'b0, 1'b0, 1'b0);

      // Reset mid-SET_MIN
      min_in = 6'd10;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("mid_mode", {6'd0, mode}, 8'd2);
      applyStimulus(1'b0, 1'b1);
      checkLoads("mid_inc", 1'b0, 1'b1, 1'b0);
      checkOutput("mid_data", {2'd0, load_data}, 8'd11);
      clear = 1'b1; inc_btn = 1'b1;
      step();
      inc_btn = 1'b0;
      checkLoads("clr_cycle", 1'b0, 1'b0, 1'b0);
      step();
      clear = 1'b0; cyc = 0;
      checkOutput("clr_mode", {6'd0, mode}, 8'd0);
      checkOutput("clr_run_en", {7'd0, run_en}, 8'd1);
      checkOutput("clr_load_data", {2'd0, load_data}, 8'd0);
      checkLoads("clr", 1'b0, 1'b0, 1'b0);
      checkEnables("clr", 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkLoads("clr_after", 1'b0, 1'b0, 1'b0);

      // Blink in SET_MIN: blink_phase = (n/8)%2, slot = (n/4)%3
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("blk_mode", {6'd0, mode}, 8'd2);
      run_to(4);  checkEnables("blk4", 1'b0, 1'b1, 1'b0);
      run_to(24); checkEnables("blk24", 1'b1, 1'b0, 1'b0);
      run_to(28); checkEnables("blk28", 1'b0, 1'b0, 1'b0);
      run_to(31); checkEnables("blk31", 1'b0, 1'b0, 1'b0);
      run_to(32); checkEnables("blk32", 1'b0, 1'b0, 1'b1);
      run_to(52); checkEnables("blk52", 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
